// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch button conditioning, run/pause/lap/clear FSM and tick prescaler
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 500000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_lap,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       disp_freeze,
    output logic [1:0] state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] D_MAX = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LAP   = 2'b11
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          clr_d;

    // Bit 0 is the start button, bit 1 is the lap button.
    logic [1:0]    btn_raw;
    logic [1:0]    ff1;
    logic [1:0]    ff2;
    logic [1:0]    lvl;
    logic [1:0]    lvl_d;
    logic [1:0]    press;
    logic [DW-1:0] dcnt [2];

    logic [PW-1:0] pcnt;
    logic          wrap;

    assign btn_raw = {btn_lap, btn_start};
    assign wrap    = (pcnt == P_MAX);

    // Synchronise, debounce and rising-edge detect both buttons
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1   <= '0;
            ff2   <= '0;
            lvl   <= '0;
            lvl_d <= '0;
            press <= '0;
            for (int i = 0; i < 2; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            ff1   <= btn_raw;
            ff2   <= ff1;
            lvl_d <= lvl;
            press <= lvl & ~lvl_d;
            for (int i = 0; i < 2; i++) begin
                if (ff2[i] == lvl[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == D_MAX) begin
                    lvl[i]  <= ff2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    // State register; the clear strobe is registered alongside so it lands on the first IDLE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_clr <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_clr <= clr_d;
        end
    end

    // Next state: a start press wins over a lap press in the same cycle
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        if (press[0]) begin
            case (state_q)
                S_IDLE, S_PAUSE: state_d = S_RUN;
                default:         state_d = S_PAUSE;
            endcase
        end else if (press[1]) begin
            case (state_q)
                S_RUN:   state_d = S_LAP;
                S_LAP:   state_d = S_RUN;
                default: begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                end
            endcase
        end
    end

    // Output decode from the registered state
    always_comb begin
        state       = state_q;
        disp_freeze = (state_q == S_LAP);
    end

    // Prescaler: cleared in IDLE, frozen in PAUSE, free-running in RUN and LAP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt   <= '0;
            cnt_en <= 1'b0;
        end else begin
            cnt_en <= 1'b0;
            case (state_q)
                S_IDLE:  pcnt <= '0;
                S_PAUSE: pcnt <= pcnt;
                default: begin
                    pcnt   <= wrap ? '0 : pcnt + 1'b1;
                    // A strobe falling on the edge that leaves RUN/LAP is dropped
                    cnt_en <= wrap && (state_d == S_RUN || state_d == S_LAP);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

    localparam int TD = 5;
    localparam int DB = 4;

    logic       clk;
    logic       rst;
    logic       btn_start;
    logic       btn_lap;
    logic       cnt_en;
    logic       cnt_clr;
    logic       disp_freeze;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_start   (btn_start),
        .btn_lap     (btn_lap),
        .cnt_en      (cnt_en),
        .cnt_clr     (cnt_clr),
        .disp_freeze (disp_freeze),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw-sample history, windowed acceptance, table FSM, modular phase
    bit         hist [2][64];
    bit         m_lvl [2];
    bit         rise1 [2];
    bit         rise2 [2];
    int         ecnt;
    int         phase;
    logic [1:0] m_state;
    bit         m_clr;
    bit         m_en;
    logic [1:0] on_start [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
    logic [1:0] on_lap   [4] = '{2'd0, 2'd3, 2'd0, 2'd1};

    typedef struct {
        bit         s;
        bit         l;
        int         n;
        logic [1:0] st;
        bit         frz;
        int         ens;
        int         clrs;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 64; k++) hist[b][k] = 1'b0;
            m_lvl[b] = 1'b0;
            rise1[b] = 1'b0;
            rise2[b] = 1'b0;
        end
        ecnt    = 0;
        phase   = 0;
        m_state = 2'd0;
        m_clr   = 1'b0;
        m_en    = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit l);
        logic [1:0] old;
        bit         diff;
        bit         rn [2];
        ecnt++;
        hist[0][ecnt & 63] = s;
        hist[1][ecnt & 63] = l;
        old   = m_state;
        m_clr = 1'b0;
        m_en  = 1'b0;
        if (rise2[0]) begin
            m_state = on_start[old];
        end else if (rise2[1]) begin
            m_state = on_lap[old];
            m_clr   = (on_lap[old] == 2'd0);
        end
        if (old == 2'd0) begin
            phase = 0;
        end else if (old != 2'd2) begin
            phase = (phase + 1) % TD;
            m_en  = (phase == 0) && (m_state == 2'd1 || m_state == 2'd3);
        end
        for (int b = 0; b < 2; b++) begin
            diff = 1'b1;
            for (int j = 0; j < DB; j++) begin
                if (hist[b][(ecnt - 2 - j) & 63] == m_lvl[b]) diff = 1'b0;
            end
            rn[b] = diff && !m_lvl[b];
            if (diff) m_lvl[b] = !m_lvl[b];
            rise2[b] = rise1[b];
            rise1[b] = rn[b];
        end
    endtask

    task automatic cyc(input bit s, input bit l);
        logic [4:0] got;
        logic [4:0] exp;
        btn_start = s;
        btn_lap   = l;
        @(posedge clk);
        #1;
        model_step(s, l);
        got = {state, disp_freeze, cnt_clr, cnt_en};
        exp = {m_state, (m_state == 2'd3), m_clr, m_en};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL cycle_%0d got=%b exp=%b (state,freeze,clr,en)", ecnt, got, exp);
        end
    endtask

    // Entered at posedge+1; asserts reset between edges and releases it at posedge+1
    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        chk("rst_async_outputs", {27'd0, state, disp_freeze, cnt_clr, cnt_en}, 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int         hit;
        int         en_cnt;
        int         clr_cnt;
        logic [1:0] r;
        int         n;

        tbl[0]  = '{1'b1, 1'b0, 10, 2'b01, 1'b0, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 13, 2'b01, 1'b0, 3, 0};
        tbl[2]  = '{1'b0, 1'b1, 10, 2'b11, 1'b1, 2, 0};
        tbl[3]  = '{1'b0, 1'b0, 10, 2'b11, 1'b1, 2, 0};
        tbl[4]  = '{1'b0, 1'b1, 10, 2'b01, 1'b0, 2, 0};
        tbl[5]  = '{1'b0, 1'b0, 5,  2'b01, 1'b0, 1, 0};
        tbl[6]  = '{1'b1, 1'b0, 10, 2'b10, 1'b0, 1, 0};
        tbl[7]  = '{1'b0, 1'b0, 10, 2'b10, 1'b0, 0, 0};
        tbl[8]  = '{1'b1, 1'b0, 10, 2'b01, 1'b0, 1, 0};
        tbl[9]  = '{1'b0, 1'b0, 7,  2'b01, 1'b0, 1, 0};
        tbl[10] = '{1'b1, 1'b0, 10, 2'b10, 1'b0, 1, 0};
        tbl[11] = '{1'b0, 1'b0, 6,  2'b10, 1'b0, 0, 0};
        tbl[12] = '{1'b0, 1'b1, 10, 2'b00, 1'b0, 0, 1};
        tbl[13] = '{1'b0, 1'b0, 6,  2'b00, 1'b0, 0, 0};
        tbl[14] = '{1'b0, 1'b1, 10, 2'b00, 1'b0, 0, 1};
        tbl[15] = '{1'b0, 1'b0, 4,  2'b00, 1'b0, 0, 0};
        tbl[16] = '{1'b1, 1'b0, 10, 2'b01, 1'b0, 0, 0};
        tbl[17] = '{1'b0, 1'b0, 8,  2'b01, 1'b0, 2, 0};
        tbl[18] = '{1'b1, 1'b1, 10, 2'b10, 1'b0, 1, 0};
        tbl[19] = '{1'b0, 1'b0, 6,  2'b10, 1'b0, 0, 0};

        rst       = 1'b0;
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("reset_state", {27'd0, state, disp_freeze, cnt_clr, cnt_en}, 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int v = 0; v < 20; v++) begin
            en_cnt  = 0;
            clr_cnt = 0;
            for (int i = 0; i < tbl[v].n; i++) begin
                cyc(tbl[v].s, tbl[v].l);
                en_cnt  += int'(cnt_en);
                clr_cnt += int'(cnt_clr);
            end
            chk($sformatf("vec%0d_state", v), {30'd0, state}, {30'd0, tbl[v].st});
            chk($sformatf("vec%0d_freeze", v), {31'd0, disp_freeze}, {31'd0, tbl[v].frz});
            chk($sformatf("vec%0d_en_count", v), en_cnt, tbl[v].ens);
            chk($sformatf("vec%0d_clr_count", v), clr_cnt, tbl[v].clrs);
        end

        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);
        chk("lap_to_idle", {30'd0, state}, 32'd0);

        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0);
        chk("glitch_ignored", {30'd0, state}, 32'd0);

        hit = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 1'b0);
            if (hit == 0 && state == 2'd1) hit = i;
        end
        chk("clean_press_edge", hit, 8);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);

        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0);
        chk("held_pause", {30'd0, state}, 32'd2);
        async_reset();
        hit = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 1'b0);
            if (hit == 0 && state == 2'd1) hit = i;
        end
        chk("rst_held_press_edge", hit, 8);

        for (int seg = 0; seg < 250; seg++) begin
            r = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 14);
            if ($urandom_range(0, 39) == 0) async_reset();
            for (int i = 0; i < n; i++) cyc(r[0], r[1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch time-keeping datapath. It conditions the two push buttons (synchronise, debounce, edge-detect) and runs a four-state run/pause/lap/clear FSM. It produces the 100 Hz count-enable strobe, the counter clear pulse and the display-freeze level that drive the BCD counter chain and the display mux.

## Interface
- `TICK_DIV`, 500000: clk cycles per count-enable strobe (100 Hz at 50 MHz); must be ≥2.
- `DB_CYCLES`, 1000000: consecutive stable cycles needed to accept a button level (20 ms at 50 MHz); must be ≥2.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn_start`  in  1  raw start/stop button; asynchronous, bouncy, active-high.
- `btn_lap`  in  1  raw lap/reset button; asynchronous, bouncy, active-high.
- `cnt_en`  out  1  one-cycle strobe; the counter chain advances by 0.01 s.
- `cnt_clr`  out  1  one-cycle strobe; the counter chain clears to 00:00.00.
- `disp_freeze`  out  1  level; the display holds its last latched value.
- `state`  out  2  current FSM state for status LEDs: IDLE=00, RUN=01, PAUSE=10, LAP=11.

## Operation
- **Button path** (per button, identical):
  - Two-flop synchroniser ff1→ff2.
  - Debounce counter `dcnt`. It is cleared whenever ff2 equals the accepted level `lvl`. Otherwise it increments.
  - When `dcnt` = DB_CYCLES−1 and ff2 still differs from `lvl`, `lvl` takes ff2 on the next edge and `dcnt` clears.
  - A registered rising-edge detector on `lvl` gives internal one-cycle `press_start` / `press_lap`.
  - Releases are debounced but produce no event.
- **FSM** (registered, changes only on a press event):
  - IDLE: start→RUN. lap→IDLE and pulse `cnt_clr` (harmless re-clear).
  - RUN: start→PAUSE. lap→LAP.
  - LAP: start→PAUSE (display unfreezes, shows the stopped time). lap→RUN (display unfreezes).
  - PAUSE: start→RUN. lap→IDLE and pulse `cnt_clr`.
- **Simultaneous events:** `press_start` and `press_lap` in the same cycle → start wins and the lap press is discarded.
- **Prescaler `pcnt`** (width ⌈log2 TICK_DIV⌉):
  - Cleared to 0 in IDLE.
  - Holds its value in PAUSE, so resume keeps sub-tick phase.
  - Increments in RUN and LAP. At TICK_DIV−1 it wraps to 0 and `cnt_en` is high for the following single cycle.
- **Output decode:**
  - `disp_freeze` = 1 exactly while state = LAP.
  - `cnt_en` is never high in IDLE or PAUSE.
  - The `cnt_clr` pulse coincides with the first cycle of IDLE.
- **Reset** (async, any time, mid-debounce or mid-tick): state=IDLE; `pcnt`, `dcnt`, ff1, ff2, `lvl` and edge registers = 0; `cnt_en`=0, `cnt_clr`=0, `disp_freeze`=0, `state`=00.
  - A button held through reset release is seen as a fresh press once debounced.

## Timing
- Edge 1 is the first clk edge sampling a raw button high, with the button then held stable:
  - ff2=1 at edge 2.
  - `lvl`=1 at edge DB_CYCLES+2.
  - press pulse high after edge DB_CYCLES+3.
  - `state`, `disp_freeze` and `cnt_clr` update at edge DB_CYCLES+4.
- Raw pulses or bounces shorter than DB_CYCLES stable cycles after synchronisation → no event, no output change.
- Counting strobes:
  - On entering RUN from IDLE, the first `cnt_en` is high in the cycle following edge TICK_DIV after the state-change edge.
  - After that, `cnt_en` is high once every TICK_DIV cycles, uninterrupted across RUN↔LAP transitions.
- Pause and resume:
  - PAUSE entered with `pcnt`=k → after resume, the first `cnt_en` comes TICK_DIV−k cycles later.
  - A strobe that would land on the same edge that enters PAUSE is suppressed.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use TICK_DIV=5, DB_CYCLES=4.
- **Reset:** assert `rst` mid-run with a button held → all outputs 0 immediately, without waiting for a clk edge; `state`=00. After release, with the button still held, `state`=01 on edge 8.
- **Debounce:** `btn_start` high for 3 cycles, low 2, high 2, then low → no state change. A clean 10-cycle press → IDLE→RUN at edge 8 after the first high sample.
- **Run cadence:** in RUN for 23 cycles → `cnt_en` pulses 4 times, spaced exactly 5 cycles, each 1 cycle wide. `cnt_clr`=0 and `disp_freeze`=0 throughout.
- **Lap:** RUN, press lap → `state`=11 and `disp_freeze`=1 while `cnt_en` keeps its 5-cycle spacing. Press lap again → `state`=01 and `disp_freeze`=0.
- **Pause/clear:** RUN for 7 cycles (`pcnt`=2), press start → `state`=10, no `cnt_en`. Press start → first `cnt_en` 3 cycles after `state`=01. Pause, press lap → `state`=00 with exactly one `cnt_clr` cycle.
- **Simultaneous:** in RUN, both raw buttons rise on the same edge → `state`=10, not 11, and no `cnt_clr`.
